// File: rtl/bakery_sequencer.sv
// bakery_sequencer: batch recipe sequencer for the bakery plant model.
// Runs fill -> flour -> salt -> close -> pressurised mix -> convey/pour
// per pan -> drain for each start request. All decisions advance on en.
// Optional per-state watchdog: define BAKERY_SEQ_WATCHDOG_EN.
module bakery_sequencer #(
    parameter int unsigned FLOUR_PORTIONS = 4,
    parameter int unsigned SALT_PORTIONS  = 2,
    parameter int unsigned MIX_TICKS      = 50,
    parameter int unsigned PANS           = 4,
    parameter int unsigned TIMEOUT_TICKS  = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       abort,
    input  logic       Y_water_base,
    input  logic       Y_water_middle,
    input  logic       Y_water_top,
    input  logic       Y_flour,
    input  logic       Y_salt,
    input  logic       Y_flour_remain,
    input  logic       Y_salt_remain,
    input  logic       S_cover_closed,
    input  logic       S_pressure_high,
    input  logic       Y_pan,
    input  logic       Y_pan_full,
    output logic       X_water,
    output logic       X_flour,
    output logic       X_salt,
    output logic       X_cover,
    output logic       X_pressurize,
    output logic       X_mixer,
    output logic       X_pan_conveyor,
    output logic       X_dispenser,
    output logic       X_drain,
    output logic [3:0] state,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FILL   = 4'd1;
    localparam logic [3:0] S_FLOUR  = 4'd2;
    localparam logic [3:0] S_SALT   = 4'd3;
    localparam logic [3:0] S_CLOSE  = 4'd4;
    localparam logic [3:0] S_MIX    = 4'd5;
    localparam logic [3:0] S_CONVEY = 4'd6;
    localparam logic [3:0] S_POUR   = 4'd7;
    localparam logic [3:0] S_DRAIN  = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;
    localparam logic [3:0] S_SAFE   = 4'd10;
    localparam logic [3:0] S_FAULT  = 4'd11;

    localparam int unsigned MIX_W     = $clog2(MIX_TICKS + 1);
    localparam logic [3:0]  FLOUR_LIM = 4'(FLOUR_PORTIONS);
    localparam logic [3:0]  SALT_LIM  = 4'(SALT_PORTIONS);
    localparam logic [3:0]  PAN_LIM   = 4'(PANS);
    localparam logic [MIX_W-1:0] MIX_LIM = MIX_W'(MIX_TICKS);

    logic [3:0]       state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [3:0]       flour_cnt_q, flour_cnt_d, flour_inc;
    logic [3:0]       salt_cnt_q, salt_cnt_d, salt_inc;
    logic [3:0]       pan_cnt_q, pan_cnt_d, pan_inc;
    logic [MIX_W-1:0] mix_cnt_q, mix_cnt_d, mix_inc;
    logic             pan_low_q, pan_low_d;
    logic             done_q;
    // {water, flour, salt, cover, pressurize, mixer, pan_conveyor, dispenser, drain}
    logic [8:0]       x_q, x_d;
    logic             overfill_zone;

    assign flour_inc = (flour_cnt_q == '1) ? flour_cnt_q : flour_cnt_q + 4'd1;
    assign salt_inc  = (salt_cnt_q  == '1) ? salt_cnt_q  : salt_cnt_q  + 4'd1;
    assign pan_inc   = (pan_cnt_q   == '1) ? pan_cnt_q   : pan_cnt_q   + 4'd1;
    assign mix_inc   = (mix_cnt_q   == '1) ? mix_cnt_q   : mix_cnt_q   + MIX_W'(1);

    assign overfill_zone = (state_q == S_FILL)  || (state_q == S_FLOUR) ||
                           (state_q == S_SALT)  || (state_q == S_CLOSE) ||
                           (state_q == S_MIX);

`ifdef BAKERY_SEQ_WATCHDOG_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_TICKS);
    logic [15:0] wd_cnt_q, wd_cnt_d, wd_inc;
    logic        wd_timed;

    assign wd_inc   = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 16'd1;
    assign wd_timed = overfill_zone || (state_q == S_CONVEY) ||
                      (state_q == S_POUR) || (state_q == S_DRAIN);
`else
    localparam int unsigned unused_timeout_ticks = TIMEOUT_TICKS;
`endif

    // Next-state and counter logic; priority is abort > overfill > hopper > normal > timeout.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        flour_cnt_d = flour_cnt_q;
        salt_cnt_d  = salt_cnt_q;
        pan_cnt_d   = pan_cnt_q;
        mix_cnt_d   = mix_cnt_q;
        pan_low_d   = pan_low_q;
        if (en) begin
            case (state_q)
                S_IDLE:   if (start && !abort) state_d = S_FILL;
                S_FILL:   if (Y_water_middle) state_d = S_FLOUR;
                S_FLOUR: begin
                    // A pulse arriving with the empty flag still counts first.
                    if (Y_flour) flour_cnt_d = flour_inc;
                    if (flour_cnt_d >= FLOUR_LIM) begin
                        state_d = S_SALT;
                    end else if (!Y_flour_remain) begin
                        state_d = S_FAULT;
                        code_d  = 3'd1;
                    end
                end
                S_SALT: begin
                    if (Y_salt) salt_cnt_d = salt_inc;
                    if (salt_cnt_d >= SALT_LIM) begin
                        state_d = S_CLOSE;
                    end else if (!Y_salt_remain) begin
                        state_d = S_FAULT;
                        code_d  = 3'd2;
                    end
                end
                S_CLOSE:  if (S_cover_closed) state_d = S_MIX;
                S_MIX: begin
                    if (S_pressure_high) mix_cnt_d = mix_inc;
                    if (mix_cnt_d >= MIX_LIM) begin
                        state_d   = S_CONVEY;
                        pan_low_d = 1'b1;
                    end
                end
                S_CONVEY: begin
                    // Re-arm only after the previous pan has moved away.
                    if (!Y_pan) pan_low_d = 1'b1;
                    else if (pan_low_q) state_d = S_POUR;
                end
                S_POUR: begin
                    if (Y_pan_full) begin
                        pan_cnt_d = pan_inc;
                        if (pan_cnt_d >= PAN_LIM) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d   = S_CONVEY;
                            pan_low_d = 1'b0;
                        end
                    end
                end
                S_DRAIN:  if (!Y_water_base) state_d = S_DONE;
                S_DONE:   state_d = S_IDLE;
                S_SAFE: begin
                    if (!Y_water_base) begin
                        state_d = S_IDLE;
                        code_d  = 3'd0;
                    end
                end
                S_FAULT:  ;
                default:  state_d = S_IDLE;
            endcase
`ifdef BAKERY_SEQ_WATCHDOG_EN
            if (wd_timed && (state_d == state_q) && (wd_inc >= TIMEOUT_LIM)) begin
                state_d = S_FAULT;
                code_d  = 3'd4;
            end
`endif
            if (Y_water_top && overfill_zone) begin
                state_d = S_FAULT;
                code_d  = 3'd3;
            end
            if (abort && (state_q != S_IDLE) && (state_q != S_SAFE)) begin
                state_d = S_SAFE;
                code_d  = code_q;
            end
            if ((state_d == S_FILL) && (state_q != S_FILL)) begin
                flour_cnt_d = '0;
                salt_cnt_d  = '0;
                pan_cnt_d   = '0;
                mix_cnt_d   = '0;
                pan_low_d   = 1'b0;
            end
        end
    end

    // Actuator decode from the upcoming state so the outputs are registered.
    always_comb begin
        x_d = '0;
        case (state_d)
            S_FILL:   x_d[8] = 1'b1;
            S_FLOUR:  x_d[7] = 1'b1;
            S_SALT:   x_d[6] = 1'b1;
            S_CLOSE:  x_d[5] = 1'b1;
            S_MIX: begin
                x_d[5] = 1'b1;
                x_d[4] = !S_pressure_high;
                x_d[3] = 1'b1;
            end
            S_CONVEY: x_d[2] = 1'b1;
            S_POUR:   x_d[1] = 1'b1;
            S_DRAIN,
            S_SAFE:   x_d[0] = 1'b1;
            default:  x_d = '0;
        endcase
    end

    // State, fault code and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            code_q      <= '0;
            flour_cnt_q <= '0;
            salt_cnt_q  <= '0;
            pan_cnt_q   <= '0;
            mix_cnt_q   <= '0;
            pan_low_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            flour_cnt_q <= flour_cnt_d;
            salt_cnt_q  <= salt_cnt_d;
            pan_cnt_q   <= pan_cnt_d;
            mix_cnt_q   <= mix_cnt_d;
            pan_low_q   <= pan_low_d;
        end
    end

    // Registered actuators (sampled on en) and the one-clock done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            done_q <= 1'b0;
        end else begin
            if (en) x_q <= x_d;
            done_q <= (state_d == S_DONE) && (state_q != S_DONE);
        end
    end

`ifdef BAKERY_SEQ_WATCHDOG_EN
    // Per-state tick counter, restarted on every state change.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_d != state_q) wd_cnt_d = '0;
        else if (en)            wd_cnt_d = wd_inc;
    end

    // Watchdog register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_cnt_q <= '0;
        else     wd_cnt_q <= wd_cnt_d;
    end
`endif

    assign X_water        = x_q[8];
    assign X_flour        = x_q[7];
    assign X_salt         = x_q[6];
    assign X_cover        = x_q[5];
    assign X_pressurize   = x_q[4];
    assign X_mixer        = x_q[3];
    assign X_pan_conveyor = x_q[2];
    assign X_dispenser    = x_q[1];
    assign X_drain        = x_q[0];
    assign state          = state_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign fault          = (state_q == S_FAULT);
    assign fault_code     = code_q;

endmodule
